// File: rtl/slice_mux_seq.sv
// Registered N-way slice selector: manual per-cycle slice select, or a latched
// LSB-first sequence stepped by 'advance' with last/done reporting.
module slice_mux_seq #(
   parameter int SLICE_W    = 4,
   parameter int NUM_SLICES = 4,
   parameter int SEL_W      = $clog2(NUM_SLICES)
) (
   input  logic                          clk,
   input  logic                          reset_a,
   input  logic                          mode,
   input  logic [SEL_W-1:0]              sel,
   input  logic                          start,
   input  logic                          advance,
   input  logic [SLICE_W*NUM_SLICES-1:0] data_in,
   output logic [SLICE_W-1:0]            mux_out,
   output logic [SEL_W-1:0]              slice_idx,
   output logic                          out_valid,
   output logic                          last,
   output logic                          busy,
   output logic                          done
);

   localparam int DATA_W = SLICE_W * NUM_SLICES;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(NUM_SLICES - 1);
   localparam logic [SEL_W:0]   SLICE_COUNT = (SEL_W + 1)'(NUM_SLICES);

   logic [1:0]         state_q,     state_d;
   logic [DATA_W-1:0]  shadow_q,    shadow_d;
   logic [SEL_W-1:0]   counter_q,   counter_d;
   logic [SLICE_W-1:0] mux_out_q,   mux_out_d;
   logic [SEL_W-1:0]   slice_idx_q, slice_idx_d;
   logic               out_valid_q, out_valid_d;
   logic               last_q,      last_d;
   logic               busy_q,      busy_d;
   logic               done_q,      done_d;

   // Decoded loop keeps the slice pick free of a variable-width index multiply.
   function automatic logic [SLICE_W-1:0] pick_slice(input logic [DATA_W-1:0] word,
                                                     input logic [SEL_W-1:0]  idx);
      logic [SLICE_W-1:0] s;
      s = '0;
      for (int i = 0; i < NUM_SLICES; i++) begin
         if (idx == SEL_W'(i)) s = word[i*SLICE_W +: SLICE_W];
      end
      return s;
   endfunction

   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      counter_d   = counter_q;
      mux_out_d   = mux_out_q;
      slice_idx_d = slice_idx_q;
      out_valid_d = 1'b0;
      last_d      = 1'b0;
      done_d      = (state_q == ST_DONE);

      case (state_q)
         ST_IDLE: begin
            if (!mode) begin
               if ({1'b0, sel} < SLICE_COUNT) begin
                  mux_out_d   = pick_slice(data_in, sel);
                  slice_idx_d = sel;
                  out_valid_d = 1'b1;
               end else begin
                  mux_out_d = '0;
               end
            end else if (start) begin
               shadow_d  = data_in;
               counter_d = '0;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (advance) begin
               mux_out_d   = pick_slice(shadow_q, counter_q);
               slice_idx_d = counter_q;
               out_valid_d = 1'b1;
               last_d      = (counter_q == LAST_IDX);
               if (counter_q == LAST_IDX) begin
                  counter_d = '0;
                  state_d   = ST_DONE;
               end else begin
                  counter_d = counter_q + 1'b1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Busy stays up through the cycle in which done is presented.
      busy_d = (state_d != ST_IDLE) || done_d;
   end

   always_ff @(posedge clk or posedge reset_a) begin
      if (reset_a) begin
         state_q     <= ST_IDLE;
         shadow_q    <= '0;
         counter_q   <= '0;
         mux_out_q   <= '0;
         slice_idx_q <= '0;
         out_valid_q <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         counter_q   <= counter_d;
         mux_out_q   <= mux_out_d;
         slice_idx_q <= slice_idx_d;
         out_valid_q <= out_valid_d;
         last_q      <= last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign mux_out   = mux_out_q;
   assign slice_idx = slice_idx_q;
   assign out_valid = out_valid_q;
   assign last      = last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: doc/slice_mux_seq.md
Name: slice_mux_seq

Overview:
- Parametrised, registered N-way slice selector. It generalises the 2:1 nibble mux used by the sequential multiplier datapath.
- Splits a wide operand into NUM_SLICES slices of SLICE_W bits each.
- Manual mode: presents one slice per cycle, chosen by an external select.
- Sequence mode: latches the operand on start, steps through slices LSB-first under an advance enable, and reports last/done. Wider multipliers use this to feed partial-product nibbles without external counter logic.

Parameters:
- SLICE_W, 4, bits per slice (width of mux_out).
- NUM_SLICES, 4, number of slices; data_in width = SLICE_W*NUM_SLICES; must be >= 2.
- SEL_W, $clog2(NUM_SLICES), width of sel and slice_idx.

Ports:
- clk  in  1  rising-edge clock.
- reset_a  in  1  asynchronous, active-high reset.
- mode  in  1  0 = manual select, 1 = sequence; sampled only in IDLE.
- sel  in  SEL_W  manual-mode slice index.
- start  in  1  sequence-mode start request; 1-cycle pulse or level.
- advance  in  1  sequence-mode step enable.
- data_in  in  SLICE_W*NUM_SLICES  operand; slice i = data_in[i*SLICE_W +: SLICE_W].
- mux_out  out  SLICE_W  registered selected slice.
- slice_idx  out  SEL_W  index of the slice currently on mux_out.
- out_valid  out  1  mux_out holds a valid slice this cycle.
- last  out  1  the valid slice is index NUM_SLICES-1 (sequence mode only).
- busy  out  1  sequence in progress (RUN or DONE).
- done  out  1  one-cycle pulse after the last slice is emitted.

Behaviour:
- Reset (async assert, sync release):
  - mux_out=0, slice_idx=0, out_valid=0, last=0, busy=0, done=0.
  - Internal shadow register = 0, counter = 0, state = IDLE.
  - Reset mid-sequence aborts immediately; done is not pulsed.
- All outputs are registered. No combinational path from inputs to outputs.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - DONE: busy=1, done=1 for exactly one cycle, then IDLE.
- IDLE, mode=0 (manual), every edge:
  - sel < NUM_SLICES: mux_out <= slice[sel], slice_idx <= sel, out_valid <= 1, last <= 0.
  - sel >= NUM_SLICES (non-power-of-2 depth): mux_out <= 0, out_valid <= 0.
  - Latency: 1 clock. start is ignored.
- IDLE, mode=1:
  - start=0: out_valid <= 0; mux_out and slice_idx hold.
  - start=1: shadow <= data_in, counter <= 0, state -> RUN, out_valid <= 0.
  - data_in changes after the start edge have no effect on the running sequence.
- RUN, each edge:
  - advance=1: mux_out <= shadow slice[counter], slice_idx <= counter, out_valid <= 1, last <= (counter==NUM_SLICES-1).
    - If counter==NUM_SLICES-1: counter <= 0, state -> DONE.
    - Otherwise counter <= counter+1.
  - advance=0: out_valid <= 0, last <= 0; mux_out, slice_idx, counter hold (stall).
  - start, mode and sel are ignored in RUN.
- DONE, one cycle:
  - done=1, out_valid <= 0, last <= 0, then state -> IDLE.
  - start asserted during DONE is ignored; a new sequence needs start in IDLE.
- Timing with continuous advance:
  - start sampled at edge k.
  - Slice 0 valid after edge k+1; slice NUM_SLICES-1 valid after edge k+NUM_SLICES.
  - done high after edge k+NUM_SLICES+1; busy low after edge k+NUM_SLICES+2.
- Counter wrap: the counter never exceeds NUM_SLICES-1; the wrap occurs only on the last emitted slice.

Test Plan:
- Reset: assert reset_a mid-clock with data_in=16'hFFFF -> all outputs 0 immediately, with no clock edge required.
- Manual mode: data_in=16'hA7C5, mode=0, sel=0,1,2,3 on successive cycles -> mux_out = 5,C,7,A each one cycle later; out_valid=1 throughout; last=0 throughout.
- Sequence, continuous advance: data_in=16'h3F91, start pulse, advance=1 -> mux_out 1,9,F,3 on consecutive cycles; slice_idx 0..3; last only with value 3; done pulses once on the following cycle; busy then falls.
- Stall: as the previous scenario, but advance=0 for 2 cycles after slice 1 -> out_valid=0 and mux_out holds 9 during the stall; sequence resumes with F, then 3; done asserts 2 cycles later than the unstalled case.
- Shadow and ignores: start with data_in=16'h1234, then change data_in to 16'hFFFF and pulse start again during RUN -> output is 4,3,2,1; exactly one done pulse.
- Reset mid-op: assert reset_a after slice 1 -> busy=0, out_valid=0, no done pulse; a subsequent start restarts from slice 0.
